// File: rtl/johnson_ctrl_pkg.sv
// Shared types and the Johnson next-phase function for the step sequencer.
// The function works on a fixed-width container so any core width up to JMAX_W can use it.
package johnson_ctrl_pkg;

    localparam int JMAX_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    // Only the low w bits of cur are meaningful; bits at and above w come back as zero.
    function automatic logic [JMAX_W-1:0] johnson_next(
        input logic [JMAX_W-1:0] cur,
        input logic              dir,
        input int unsigned       w
    );
        logic [JMAX_W-1:0] mask;
        logic [JMAX_W-1:0] msb_sh;
        logic [JMAX_W-1:0] lsb_in;
        mask   = {JMAX_W{1'b1}} >> (JMAX_W - w);
        msb_sh = cur >> (w - 1);
        lsb_in = {{(JMAX_W-1){1'b0}}, ~cur[0]};
        if (dir == DIR_FWD) begin
            johnson_next = ((cur << 1) | {{(JMAX_W-1){1'b0}}, ~msb_sh[0]}) & mask;
        end else begin
            johnson_next = ((cur & mask) >> 1) | (lsb_in << (w - 1));
        end
    endfunction

endpackage

// File: rtl/johnson_core.sv
// Johnson phase register: advances one position forward or in reverse when en is high.
module johnson_core
    import johnson_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0]  q_q;
    logic [WIDTH-1:0]  q_d;
    logic [JMAX_W-1:0] cur_ext;
    logic [JMAX_W-1:0] nxt_ext;

    always_comb begin
        cur_ext              = '0;
        cur_ext[WIDTH-1:0]   = q_q;
        nxt_ext              = johnson_next(cur_ext, dir, WIDTH);
        q_d                  = en ? nxt_ext[WIDTH-1:0] : q_q;
    end

    // Upper container bits are always zero; fold them away so they are not flagged as dangling.
    generate
        if (WIDTH < JMAX_W) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^nxt_ext[JMAX_W-1:WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/johnson_step_ctrl.sv
// Command-driven Johnson phase sequencer: accepts (steps, dir, div), steps once per
// div+1 cycles, and reports completion with a one-cycle done pulse plus an aborted flag.
module johnson_step_ctrl
    import johnson_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             cmd_dir,
    input  logic [DIV_W-1:0] cmd_div,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic             step_pulse,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [DIV_W-1:0] pre_q,       pre_d;
    logic [DIV_W-1:0] div_q,       div_d;
    logic             dir_q,       dir_d;
    logic             aborted_q,   aborted_d;
    logic             period_end;

    assign period_end = (pre_q == div_q);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        pre_d       = pre_q;
        div_d       = div_q;
        dir_d       = dir_q;
        aborted_d   = aborted_q;
        step_pulse  = 1'b0;
        cmd_ready   = 1'b0;
        done        = 1'b0;
        busy        = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    remaining_d = cmd_steps;
                    dir_d       = cmd_dir;
                    div_d       = cmd_div;
                    pre_d       = '0;
                    aborted_d   = 1'b0;
                    state_d     = (cmd_steps == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort wins over a coincident period end: the phase must not move.
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (period_end) begin
                    step_pulse  = 1'b1;
                    pre_d       = '0;
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    pre_d = pre_q + DIV_W'(1);
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            pre_q       <= '0;
            div_q       <= '0;
            dir_q       <= DIR_FWD;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            pre_q       <= pre_d;
            div_q       <= div_d;
            dir_q       <= dir_d;
            aborted_q   <= aborted_d;
        end
    end

    assign aborted = aborted_q;

    johnson_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .en    (step_pulse),
        .dir   (dir_q),
        .q     (q)
    );

endmodule

// File: tb/tb_johnson_step_ctrl.sv
// Directed bench for johnson_step_ctrl: inputs change and outputs are sampled just after negedge.
module tb_johnson_step_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_steps = '0;
    logic       cmd_dir = 1'b0;
    logic [7:0] cmd_div = '0;
    logic       abort = 1'b0;
    logic [3:0] q;
    logic       step_pulse;
    logic       busy;
    logic       done;
    logic       aborted;

    int n_vec = 0;
    int n_err = 0;

    int         pulse_cyc[$];
    logic [3:0] q_seen[$];
    int         done_cyc;
    logic       ab_seen;

    always #5 clk = ~clk;

    johnson_step_ctrl #(.WIDTH(4), .CNT_W(8), .DIV_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_steps  (cmd_steps),
        .cmd_dir    (cmd_dir),
        .cmd_div    (cmd_div),
        .abort      (abort),
        .q          (q),
        .step_pulse (step_pulse),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted)
    );

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0; cmd_valid = 1'b0; abort = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Offer a command in cycle 0, then record pulses, the phase after each pulse and done.
    task automatic run_cmd(input int steps, input logic dir, input int div,
                           input int abort_cyc, input int max_cyc);
        logic prev_pulse;
        pulse_cyc.delete();
        q_seen.delete();
        done_cyc   = -1;
        ab_seen    = 1'bx;
        prev_pulse = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_steps = steps[7:0];
        cmd_dir   = dir;
        cmd_div   = div[7:0];
        #1;
        n_vec++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL accept_ready: cmd_ready=%b required 1", cmd_ready);
        end
        for (int c = 1; c <= max_cyc && done_cyc < 0; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            abort     = (c == abort_cyc);
            #1;
            if (prev_pulse) q_seen.push_back(q);
            prev_pulse = step_pulse;
            if (step_pulse === 1'b1) pulse_cyc.push_back(c);
            if (done === 1'b1) begin
                done_cyc = c;
                ab_seen  = aborted;
            end
        end
        abort = 1'b0;
    endtask

    task automatic test_reset();
        bit saw_done;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if (q !== 4'h0 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || step_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: q=%h ready=%b busy=%b done=%b step=%b required q=0 ready=1 busy=0 done=0 step=0",
                     q, cmd_ready, busy, done, step_pulse);
        end
        @(negedge clk);
        reset = 1'b1;
        // steps=5, div=2: first pulse in cycle 3, so q=1 in cycle 4
        @(negedge clk);
        cmd_valid = 1'b1; cmd_steps = 8'd5; cmd_dir = 1'b0; cmd_div = 8'd2;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        #1;
        n_vec++;
        if (q !== 4'h1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_prerun: q=%h busy=%b required q=1 busy=1", q, busy);
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if (q !== 4'h0 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || step_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL reset_midrun: q=%h ready=%b busy=%b done=%b step=%b required q=0 ready=1 busy=0 done=0 step=0",
                     q, cmd_ready, busy, done, step_pulse);
        end
        @(negedge clk);
        reset = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1 || busy !== 1'b0) saw_done = 1'b1;
        end
        n_vec++;
        if (saw_done) begin
            n_err++;
            $display("FAIL reset_nodone: done/busy seen=1 required 0");
        end
        run_cmd(1, 1'b0, 0, 0, 10);
        n_vec++;
        if (done_cyc != 2 || q_seen.size() != 1 || q !== 4'h1) begin
            n_err++;
            $display("FAIL reset_newcmd: done_cyc=%0d steps=%0d q=%h required done_cyc=2 steps=1 q=1",
                     done_cyc, q_seen.size(), q);
        end
        $display("reset: mid-run reset and follow-up command checked");
    endtask

    task automatic test_forward();
        logic [3:0] exp_q [8] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
        run_cmd(8, 1'b0, 0, 0, 20);
        n_vec++;
        if (q_seen.size() != 8) begin
            n_err++;
            $display("FAIL fwd_count: steps=%0d required 8", q_seen.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_vec++;
                if (q_seen[i] !== exp_q[i] || pulse_cyc[i] != i + 1) begin
                    n_err++;
                    $display("FAIL fwd_step%0d: q=%h cyc=%0d required q=%h cyc=%0d",
                             i, q_seen[i], pulse_cyc[i], exp_q[i], i + 1);
                end
            end
        end
        n_vec++;
        if (done_cyc != 9 || ab_seen !== 1'b0) begin
            n_err++;
            $display("FAIL fwd_done: done_cyc=%0d aborted=%b required 9 0", done_cyc, ab_seen);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (cmd_ready !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL fwd_ready: ready=%b done=%b required 1 0", cmd_ready, done);
        end
        $display("forward: 8 steps div=0 done_cyc=%0d q=%h", done_cyc, q);
    endtask

    task automatic test_continuation();
        int accept_cyc;
        int done2;
        bool_early_check: begin end
        accept_cyc = -1;
        done2      = -1;
        // forward 2 steps div=1 from q=0: pulses 2,4 (q=1,3), done 5, ready 6
        @(negedge clk);
        cmd_valid = 1'b1; cmd_steps = 8'd2; cmd_dir = 1'b0; cmd_div = 8'd1;
        @(negedge clk);
        // reverse request held from cycle 1 onwards
        cmd_steps = 8'd2; cmd_dir = 1'b1; cmd_div = 8'd0;
        for (int c = 1; c <= 20 && done2 < 0; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            if (accept_cyc < 0 && cmd_ready === 1'b1 && cmd_valid === 1'b1) begin
                accept_cyc = c;
                n_vec++;
                if (q !== 4'h3) begin
                    n_err++;
                    $display("FAIL cont_mid: q=%h required 3", q);
                end
            end else if (accept_cyc >= 0) begin
                cmd_valid = 1'b0;
                if (done === 1'b1) done2 = c;
            end
        end
        cmd_valid = 1'b0;
        n_vec++;
        if (accept_cyc != 6) begin
            n_err++;
            $display("FAIL cont_accept: accept_cyc=%0d required 6", accept_cyc);
        end
        n_vec++;
        if (done2 != 9 || q !== 4'h0) begin
            n_err++;
            $display("FAIL cont_end: done_cyc=%0d q=%h required 9 0", done2, q);
        end
        $display("continuation: fwd2 then rev2 accept_cyc=%0d q=%h", accept_cyc, q);
    endtask

    task automatic test_reverse();
        logic [3:0] exp_q [3] = '{4'h8, 4'hC, 4'hE};
        run_cmd(3, 1'b1, 3, 0, 30);
        n_vec++;
        if (q_seen.size() != 3) begin
            n_err++;
            $display("FAIL rev_count: steps=%0d required 3", q_seen.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_vec++;
                if (q_seen[i] !== exp_q[i] || pulse_cyc[i] != 4 * (i + 1)) begin
                    n_err++;
                    $display("FAIL rev_step%0d: q=%h cyc=%0d required q=%h cyc=%0d",
                             i, q_seen[i], pulse_cyc[i], exp_q[i], 4 * (i + 1));
                end
            end
        end
        n_vec++;
        if (done_cyc != 13 || ab_seen !== 1'b0) begin
            n_err++;
            $display("FAIL rev_done: done_cyc=%0d aborted=%b required 13 0", done_cyc, ab_seen);
        end
        $display("reverse: 3 steps div=3 done_cyc=%0d q=%h", done_cyc, q);
    endtask

    task automatic test_abort();
        // steps=10, div=1: pulses due in 2,4,6; abort in cycle 6
        run_cmd(10, 1'b0, 1, 6, 30);
        n_vec++;
        if (pulse_cyc.size() != 2 || q !== 4'h3) begin
            n_err++;
            $display("FAIL abort_steps: steps=%0d q=%h required 2 3", pulse_cyc.size(), q);
        end
        n_vec++;
        if (done_cyc != 7 || ab_seen !== 1'b1) begin
            n_err++;
            $display("FAIL abort_done: done_cyc=%0d aborted=%b required 7 1", done_cyc, ab_seen);
        end
        @(negedge clk);
        abort = 1'b1;
        #1;
        n_vec++;
        if (aborted !== 1'b1 || cmd_ready !== 1'b1 || done !== 1'b0 || step_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL abort_hold: aborted=%b ready=%b done=%b step=%b required 1 1 0 0",
                     aborted, cmd_ready, done, step_pulse);
        end
        @(negedge clk);
        abort = 1'b0;
        $display("abort: done_cyc=%0d aborted=%b q=%h", done_cyc, ab_seen, q);
    endtask

    task automatic test_zero_and_maxdiv();
        // abort raised in the DONE cycle must be ignored
        run_cmd(0, 1'b0, 5, 1, 10);
        n_vec++;
        if (done_cyc != 1 || ab_seen !== 1'b0 || pulse_cyc.size() != 0 || q !== 4'h3) begin
            n_err++;
            $display("FAIL zero_steps: done_cyc=%0d aborted=%b pulses=%0d q=%h required 1 0 0 3",
                     done_cyc, ab_seen, pulse_cyc.size(), q);
        end
        run_cmd(1, 1'b0, 255, 0, 300);
        n_vec++;
        if (pulse_cyc.size() != 1 || pulse_cyc[0] != 256) begin
            n_err++;
            $display("FAIL maxdiv_pulse: pulses=%0d first=%0d required 1 256",
                     pulse_cyc.size(), (pulse_cyc.size() > 0) ? pulse_cyc[0] : -1);
        end
        n_vec++;
        if (done_cyc != 257 || q !== 4'h7) begin
            n_err++;
            $display("FAIL maxdiv_done: done_cyc=%0d q=%h required 257 7", done_cyc, q);
        end
        $display("zero/maxdiv: done_cyc=%0d q=%h", done_cyc, q);
    endtask

    initial begin
        test_reset();
        apply_reset();
        test_forward();
        test_continuation();
        test_reverse();
        apply_reset();
        test_abort();
        test_zero_and_maxdiv();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/johnson_step_ctrl.md
# johnson_step_ctrl

Command-driven sequencer for a WIDTH-bit Johnson counter, used as a phase generator for stepper drives and multi-phase strobes. It accepts a step command (count, direction, rate) over a valid/ready handshake and advances the Johnson state forward or in reverse, one position per prescaler period. It signals completion with a one-cycle done pulse. The counter position persists between commands, so consecutive moves continue from the last phase.

## Interface
- WIDTH, 4: Johnson register width; sequence length 2*WIDTH.
- CNT_W, 8: width of step count.
- DIV_W, 8: width of prescaler divisor.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command.
- cmd_steps  in  CNT_W  number of steps to take.
- cmd_dir  in  1  step direction: 0 = forward, 1 = reverse.
- cmd_div  in  DIV_W  step period minus 1, in clk cycles.
- abort  in  1  terminate the running command.
- q  out  WIDTH  Johnson phase outputs.
- step_pulse  out  1  high in a cycle whose closing edge advances q.
- busy  out  1  command in progress (state != IDLE).
- done  out  1  one-cycle completion pulse.
- aborted  out  1  valid with done; 1 if the command ended by abort.

## Operation
- States:
  - IDLE: cmd_ready=1.
  - RUN: stepping.
  - DONE: done=1 for one cycle, then IDLE.
- Accept: cmd_valid && cmd_ready at a rising edge latches the following, then moves to RUN:
  - steps into remaining (CNT_W),
  - dir,
  - div,
  - prescaler cleared to 0.
- Zero-step command: cmd_steps==0 goes IDLE→DONE directly; q unchanged; aborted=0.
- RUN, per cycle:
  - step_pulse = (pre == div) && !abort.
  - On step_pulse: pre←0, q advances, remaining←remaining−1.
  - Otherwise: pre←pre+1, q holds.
- Forward step: q ← {q[WIDTH-2:0], ~q[WIDTH-1]}. For WIDTH=4 this gives 0,1,3,7,F,E,C,8,0.
- Reverse step: q ← {~q[0], q[WIDTH-1:1]}. For WIDTH=4 this gives 0,8,C,E,F,7,3,1,0.
- Last step: a step_pulse with remaining==1 moves to DONE with aborted=0.
- Abort:
  - Sampled only in RUN; ignored in IDLE and DONE.
  - Abort in RUN moves to DONE at the next edge with aborted=1 and suppresses the step in that cycle.
  - q holds its current phase.
- aborted is registered; it is held until the next accept, and is meaningful while done=1.
- The pre==div compare is full DIV_W width. div=all-ones gives a period of 2^DIV_W cycles.
- Maximum steps per command: 2^CNT_W−1.
- Reset (asynchronous, any state, including mid-RUN):
  - q=0, state=IDLE, pre=0, remaining=0, aborted=0.
  - Outputs during reset: cmd_ready=1, busy=0, done=0, step_pulse=0.
- Only the 2*WIDTH legal Johnson codes are reachable; no illegal-state recovery is required.

## Timing
- Accept at edge k → RUN from cycle k+1.
- With N≥1 steps and divisor D:
  - step_pulse is high in cycles k+1+D + j·(D+1), for j = 0..N−1.
  - q updates at the end of each of those cycles.
- done is high in cycle k+N·(D+1)+1; cmd_ready returns in cycle k+N·(D+1)+2.
- Zero-step command: done in cycle k+1.
- A new command cannot be accepted in the DONE cycle; minimum spacing between accepts is N·(D+1)+2 cycles.
- Abort high in RUN cycle m → done in cycle m+1, aborted=1; no step in cycle m.
- All outputs are registered or decoded from registered state and pre==div. step_pulse additionally depends combinationally on abort.

## Structure
- Package johnson_ctrl_pkg holds:
  - state encoding (IDLE, RUN, DONE),
  - DIR_FWD=0 and DIR_REV=1,
  - a function returning the next Johnson state for a given q and dir.
- Sub-module johnson_core(WIDTH):
  - Ports: clk, reset (async active-low), en, dir, q.
  - Registers q and applies the next-state function when en=1.
  - The controller drives en=step_pulse.
- The controller holds the FSM, prescaler, remaining counter and handshake.

## Test plan
- Reset mid-RUN (steps=5, div=2, reset asserted after 4 cycles) → q=0, busy=0, cmd_ready=1, no done pulse; after release, a new command is accepted normally.
- Forward, steps=8, div=0, from q=0 → q sequence 1,3,7,F,E,C,8,0 on consecutive cycles; done 9 cycles after accept; aborted=0.
- Reverse, steps=3, div=3, from q=0 → q=8 then C then E, each 4 cycles apart; done in cycle k+13.
- Continuation: forward 2 steps, then reverse 2 steps → q ends at 0; no reset of q between commands; cmd_valid held during RUN is not accepted until cmd_ready=1.
- Abort: steps=10, div=1, abort asserted in the cycle of the third step_pulse → only 2 steps taken (q=3), done the next cycle with aborted=1.
- Zero steps and max divisor: steps=0 → done at k+1, q unchanged; steps=1, div=255 → single step_pulse at cycle k+256.
